seq_divider_16: RTL and testbench

//   Unsigned iterative restoring divider: the inverse-operation companion to the

---
 rtl/seq_divider_16_pkg.sv | 14 +
 rtl/seq_divider_16_sub_step.sv | 41 ++++
 rtl/seq_divider_16.sv | 102 ++++++++++
 tb/tb_seq_divider_16.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/seq_divider_16_pkg.sv
// Shared definitions for the iterative restoring divider: FSM encoding,
// default operand width and the carry-lookahead block size.
package seq_divider_16_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int CLA_BLK   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_16_sub_step.sv
// Trial subtractor for one restoring-division step: rx - {0,divisor} computed as
// rx + ~{0,divisor} + 1 on cascaded 4-bit carry-lookahead blocks.
module seq_divider_16_sub_step
    import seq_divider_16_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   rx,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] diff,
    output logic             no_borrow
);

    localparam int NB = WIDTH / CLA_BLK;

    logic [WIDTH-1:0] b_inv;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;

    assign b_inv = ~divisor;
    assign g     = rx[WIDTH-1:0] & b_inv;
    assign p     = rx[WIDTH-1:0] ^ b_inv;
    assign c[0]  = 1'b1;

    for (genvar k = 0; k < NB; k++) begin : g_cla
        localparam int B = CLA_BLK * k;
        assign c[B+1] = g[B] | (p[B] & c[B]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & c[B]);
        assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                      | (p[B+3] & p[B+2] & p[B+1] & g[B])
                      | (p[B+3] & p[B+2] & p[B+1] & p[B] & c[B]);
    end

    assign diff = p ^ c[WIDTH-1:0];
    // Extra top bit: the zero-extended divisor inverts to 1 there, so carry-out is a | c.
    assign no_borrow = rx[WIDTH] | c[WIDTH];

endmodule

// File: rtl/seq_divider_16.sv
// Unsigned iterative restoring divider, one quotient bit per clock, with a
// start/busy/done handshake and a divide-by-zero short cut.
module seq_divider_16
    import seq_divider_16_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q_reg, r_reg, dvs_reg;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   rx;
    logic [WIDTH-1:0] diff;
    logic             no_borrow;
    logic             accept;
    logic             last;

    assign accept = start && (state != RUN);
    assign last   = (cnt == CNT_W'(WIDTH));
    assign rx     = {r_reg, q_reg[WIDTH-1]};

    seq_divider_16_sub_step #(.WIDTH(WIDTH)) u_sub_step (
        .rx       (rx),
        .divisor  (dvs_reg),
        .diff     (diff),
        .no_borrow(no_borrow)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = start ? RUN : IDLE;
            RUN:        if (dvs_reg == '0 || last) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            q_reg       <= '0;
            r_reg       <= '0;
            dvs_reg     <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            if (accept) begin
                dvs_reg     <= divisor;
                q_reg       <= dividend;
                r_reg       <= '0;
                cnt         <= '0;
                busy        <= 1'b1;
                quotient    <= '0;
                remainder   <= '0;
                div_by_zero <= 1'b0;
            end else if (state == RUN) begin
                if (dvs_reg == '0) begin
                    // q_reg still holds the untouched dividend here
                    quotient    <= '1;
                    remainder   <= q_reg;
                    div_by_zero <= 1'b1;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                end else if (last) begin
                    quotient  <= q_reg;
                    remainder <= r_reg;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                end else begin
                    if (no_borrow) begin
                        r_reg <= diff;
                        q_reg <= {q_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        r_reg <= rx[WIDTH-1:0];
                        q_reg <= {q_reg[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_divider_16.sv
// Directed and randomised checks of seq_divider_16 against hand-computed values
// and the simulator's own / and % operators.
module tb_seq_divider_16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        busy, done, div_by_zero;
    logic [15:0] quotient, remainder;

    int checks = 0;
    int errors = 0;
    int lat;
    logic        seen_done;
    logic [15:0] ra, rb;

    seq_divider_16 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents operands so the next edge (t0) accepts them; returns at t0+1ns.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        start = 1'b0;
    endtask

    // Counts edges after t0 until done is seen; gives up after 40.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < 40);
    endtask

    initial begin
        // reset state
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dz", div_by_zero, 0);
        #9 rst_n = 1'b1;
        tick();

        // 100/7 with an ignored start at t0+5 carrying other operands
        start_op(16'd100, 16'd7);
        chk("b7_busy_t0", busy, 1);
        for (int i = 1; i < 5; i++) tick();
        start = 1'b1; dividend = 16'd50; divisor = 16'd3;
        tick();
        start = 1'b0; dividend = 16'd0; divisor = 16'd0;
        for (int i = 6; i <= 16; i++) tick();
        chk("b7_busy_t16", busy, 1);
        chk("b7_done_t16", done, 0);
        tick();
        chk("b7_done_t17", done, 1);
        chk("b7_busy_t17", busy, 0);
        chk("b7_q", quotient, 14);
        chk("b7_r", remainder, 2);
        chk("b7_dz", div_by_zero, 0);
        tick();
        chk("b7_done_pulse", done, 0);
        chk("b7_q_held", quotient, 14);

        // 0xFFFF/1
        start_op(16'hFFFF, 16'd1);
        wait_done(lat);
        chk("ff1_lat", lat, 17);
        chk("ff1_q", quotient, 16'hFFFF);
        chk("ff1_r", remainder, 0);

        // dividend < divisor
        start_op(16'd3, 16'h8000);
        wait_done(lat);
        chk("small_lat", lat, 17);
        chk("small_q", quotient, 0);
        chk("small_r", remainder, 3);

        // divide by zero: one busy cycle, no iterations
        tick();
        start_op(16'd5, 16'd0);
        chk("dz_busy", busy, 1);
        wait_done(lat);
        chk("dz_lat", lat, 1);
        chk("dz_q", quotient, 16'hFFFF);
        chk("dz_r", remainder, 5);
        chk("dz_flag", div_by_zero, 1);
        chk("dz_busy_after", busy, 0);

        // back-to-back: start presented in the done cycle
        start_op(16'd200, 16'd9);
        wait_done(lat);
        chk("bb1_q", quotient, 22);
        chk("bb1_r", remainder, 2);
        start_op(16'hFFFF, 16'h00FF);
        chk("bb2_busy", busy, 1);
        chk("bb2_done_clr", done, 0);
        chk("bb2_q_clr", quotient, 0);
        wait_done(lat);
        chk("bb2_lat", lat, 17);
        chk("bb2_q", quotient, 16'h0101);
        chk("bb2_r", remainder, 0);
        chk("bb2_dz", div_by_zero, 0);

        // reset in the middle of a run
        start_op(16'd100, 16'd7);
        for (int i = 1; i < 8; i++) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_q", quotient, 0);
        chk("mid_rst_r", remainder, 0);
        #3 rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        chk("mid_rst_no_done", seen_done, 0);
        chk("mid_rst_idle_busy", busy, 0);
        start_op(16'd1000, 16'd10);
        wait_done(lat);
        chk("k10_lat", lat, 17);
        chk("k10_q", quotient, 100);
        chk("k10_r", remainder, 0);

        // random operand pairs against the language's own division
        for (int n = 0; n < 200; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom_range(1, 65535));
            if (n % 3 == 0) rb = rb & 16'h00FF;
            if (rb == 16'd0) rb = 16'd1;
            start_op(ra, rb);
            wait_done(lat);
            chk("rnd_lat", lat, 17);
            chk("rnd_q", quotient, ra / rb);
            chk("rnd_r", remainder, ra % rb);
            chk("rnd_recon", (32'(quotient) * 32'(rb)) + 32'(remainder), 32'(ra));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
